// File: rtl/t0_pkg.sv
// t0_pkg: shared constants, FSM state type and saturating-add helper for the T0 bus decoder
package t0_pkg;
  localparam int T0_N = 8;
  localparam int T0_STRIDE = 1;
  localparam int T0_CNT_W = 16;
  typedef enum logic {IDLE, TRACK} t0_state_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/t0_popcount.sv
// t0_popcount: combinational count of ones; din W-bit vector in, cnt number of set bits out
module t0_popcount #(
  parameter int W = 9,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  input  logic          unused_tie,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(din[i]);
  end
endmodule

// File: rtl/t0_bus_decoder.sv
// t0_bus_decoder: rebuilds the address stream from a T0-encoded bus and measures its switching activity
// ports: ck clock, rst async active-low reset, bus_in/inc_in/valid_in encoded word, clr counter/err clear,
//        addr_out/valid_out decoded word, toggles bus transitions, inc_words INC-coded words, err sticky protocol error
module t0_bus_decoder
  import t0_pkg::*;
#(
  parameter int N = T0_N,
  parameter int STRIDE = T0_STRIDE,
  parameter int CNT_W = T0_CNT_W
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N-1:0]     bus_in,
  input  logic             inc_in,
  input  logic             valid_in,
  input  logic             clr,
  output logic [N-1:0]     addr_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] toggles,
  output logic [CNT_W-1:0] inc_words,
  output logic             err
);
  localparam int PW = $clog2(N + 2);
  t0_state_t state;
  logic [N:0] prev_bus;
  logic [N:0] cur;
  logic [PW-1:0] delta;
  logic [N-1:0] nxt;
  assign cur = {inc_in, bus_in};
  // with no reference yet, an INC word decodes as if the previous address were zero
  assign nxt = !inc_in ? bus_in : (state == IDLE) ? N'(STRIDE) : addr_out + N'(STRIDE);
  t0_popcount #(.W(N + 1), .CW(PW)) u_pop (.din(cur ^ prev_bus), .unused_tie(1'b0), .cnt(delta));
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      addr_out <= '0;
      valid_out <= 1'b0;
      toggles <= '0;
      inc_words <= '0;
      err <= 1'b0;
      state <= IDLE;
      prev_bus <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        addr_out <= nxt;
        state <= TRACK;
        prev_bus <= cur;
      end
      // clear beats a same-cycle word's statistics, but not its decoding
      if (clr) begin
        toggles <= '0;
        inc_words <= '0;
        err <= 1'b0;
      end else if (valid_in) begin
        toggles <= CNT_W'(sat_add(32'(toggles), 32'(delta), CNT_W));
        inc_words <= CNT_W'(sat_add(32'(inc_words), {31'd0, inc_in}, CNT_W));
        if (inc_in && state == IDLE) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_t0_bus_decoder.sv
// tb_t0_bus_decoder: directed scoreboard bench for t0_bus_decoder, plus a narrow-counter instance for saturation
module tb_t0_bus_decoder;
  logic ck = 1'b0;
  logic rst = 1'b0;
  logic [7:0] bus_in = '0;
  logic inc_in = 1'b0;
  logic valid_in = 1'b0;
  logic clr = 1'b0;
  logic [7:0] addr_out, addr_b;
  logic valid_out, valid_b, err, err_b;
  logic [15:0] toggles, inc_words;
  logic [3:0] toggles_b, inc_words_b;
  int checks = 0;
  int passed = 0;
  logic [7:0] sb[$];
  logic [7:0] m_addr;
  logic [8:0] m_prev;
  bit m_track, m_err;
  int m_tog, m_inc;

  t0_bus_decoder dut (
    .ck(ck), .rst(rst), .bus_in(bus_in), .inc_in(inc_in), .valid_in(valid_in), .clr(clr),
    .addr_out(addr_out), .valid_out(valid_out), .toggles(toggles), .inc_words(inc_words), .err(err)
  );
  t0_bus_decoder #(.CNT_W(4)) dut_b (
    .ck(ck), .rst(rst), .bus_in(bus_in), .inc_in(inc_in), .valid_in(valid_in), .clr(clr),
    .addr_out(addr_b), .valid_out(valid_b), .toggles(toggles_b), .inc_words(inc_words_b), .err(err_b)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_addr = '0;
    m_prev = '0;
    m_track = 1'b0;
    m_err = 1'b0;
    m_tog = 0;
    m_inc = 0;
    sb.delete();
  endtask

  task automatic step(input bit v, input bit inc, input logic [7:0] bus, input bit c);
    logic [7:0] e;
    int d;
    valid_in = v;
    inc_in = inc;
    bus_in = bus;
    clr = c;
    if (v) begin
      e = inc ? (m_track ? m_addr + 8'd1 : 8'd1) : bus;
      d = $countones({inc, bus} ^ m_prev);
      if (!c) begin
        if (inc && !m_track) m_err = 1'b1;
        m_tog = (m_tog + d > 65535) ? 65535 : m_tog + d;
        if (inc) m_inc = (m_inc == 65535) ? 65535 : m_inc + 1;
      end
      m_prev = {inc, bus};
      m_addr = e;
      m_track = 1'b1;
      sb.push_back(e);
    end
    if (c) begin
      m_tog = 0;
      m_inc = 0;
      m_err = 1'b0;
    end
    @(posedge ck);
    #1;
    valid_in = 1'b0;
    clr = 1'b0;
    check("valid_out", 32'(valid_out), 32'(v));
    if (valid_out) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("addr_out", 32'(addr_out), 32'(sb.pop_front()));
    end else check("addr_hold", 32'(addr_out), 32'(m_addr));
    check("toggles", 32'(toggles), 32'(m_tog));
    check("inc_words", 32'(inc_words), 32'(m_inc));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_toggles", 32'(toggles), 32'd0);
    check("rst_inc_words", 32'(inc_words), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_toggles_b", 32'(toggles_b), 32'd0);
    model_reset();
    @(negedge ck);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    step(1, 0, 8'h10, 0);
    check("tp1_a0", 32'(addr_out), 32'h10);
    step(1, 1, 8'hAA, 0);
    check("tp1_a1", 32'(addr_out), 32'h11);
    step(1, 1, 8'h33, 0);
    check("tp1_a2", 32'(addr_out), 32'h12);
    step(1, 0, 8'h80, 0);
    check("tp1_a3", 32'(addr_out), 32'h80);
    step(0, 0, 8'h00, 0);
    check("tp1_inc_words", 32'(inc_words), 32'd2);
    step(1, 0, 8'hFE, 0);
    step(1, 1, 8'h00, 0);
    check("wrap_ff", 32'(addr_out), 32'hFF);
    step(1, 1, 8'h00, 0);
    check("wrap_00", 32'(addr_out), 32'h00);
    check("wrap_err", 32'(err), 32'd0);
    do_reset();
    step(1, 1, 8'h55, 0);
    check("idle_inc_err", 32'(err), 32'd1);
    check("idle_inc_addr", 32'(addr_out), 32'h01);
    step(1, 0, 8'h20, 0);
    check("err_sticky", 32'(err), 32'd1);
    check("after_err_addr", 32'(addr_out), 32'h20);
    step(0, 0, 8'h00, 1);
    check("clr_err", 32'(err), 32'd0);
    do_reset();
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 1, 8'hFF, 0);
    step(1, 0, 8'h0F, 0);
    check("activity_total", 32'(toggles), 32'd14);
    check("activity_total_b", 32'(toggles_b), 32'd14);
    do_reset();
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'h00, 0);
    check("sat_b", 32'(toggles_b), 32'd15);
    check("sat_wide", 32'(toggles), 32'd16);
    step(1, 0, 8'hFF, 0);
    check("sat_b_hold", 32'(toggles_b), 32'd15);
    check("sat_wide_more", 32'(toggles), 32'd24);
    step(1, 1, 8'h00, 1);
    check("clr_valid_addr", 32'(addr_out), 32'h00);
    check("clr_valid_toggles", 32'(toggles), 32'd0);
    check("clr_valid_inc", 32'(inc_words), 32'd0);
    step(1, 1, 8'h00, 0);
    check("post_clr_delta", 32'(toggles), 32'd0);
    check("post_clr_inc", 32'(inc_words), 32'd1);
    do_reset();
    step(1, 1, 8'h00, 1);
    check("idle_inc_clr_err", 32'(err), 32'd0);
    check("idle_inc_clr_addr", 32'(addr_out), 32'h01);
    step(1, 0, 8'h42, 0);
    step(1, 1, 8'h00, 0);
    do_reset();
    step(1, 1, 8'h00, 0);
    check("midreset_err", 32'(err), 32'd1);
    check("midreset_addr", 32'(addr_out), 32'h01);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
